// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one spi_master among NUM_REQ requesters, with locked bursts and timeout.
// Latency: gnt/m_spi_start one edge after req is sampled in IDLE; ack two edges after spi_done rises.
// Backpressure: requesters hold req (level) until granted; GAP_CYCLES idle cycles follow every byte.
module spi_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int GAP_CYCLES     = 15,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          arstn,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          timeout_err,
  output logic                          busy,
  output logic [DATA_WIDTH-1:0]         m_data_send,
  output logic                          m_spi_start,
  input  logic                          m_spi_done,
  input  logic [DATA_WIDTH-1:0]         m_data_recv
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] TO_END   = CW'(TIMEOUT_CYCLES - 2);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_RESP, S_GAP} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] win;
  logic          last_q;
  logic          done_q;
  logic          done_qq;
  logic [CW-1:0] to_cnt;
  logic [GW-1:0] gap_cnt;

  logic [IW-1:0] pick;
  logic          pick_vld;
  logic [IW:0]   cand;
  logic          done_evt;

  assign done_evt = done_q & ~done_qq;

  // First requester at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (!pick_vld && req[cand[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick     = cand[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state       <= S_IDLE;
      ptr         <= '0;
      win         <= '0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      done_qq     <= 1'b0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      gnt         <= '0;
      ack         <= '0;
      rsp_data    <= '0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      m_data_send <= '0;
      m_spi_start <= 1'b0;
    end else begin
      done_q      <= m_spi_done;
      done_qq     <= done_q;
      ack         <= '0;
      timeout_err <= 1'b0;
      m_spi_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            win         <= pick;
            gnt         <= NUM_REQ'(1) << pick;
            m_data_send <= req_data[pick*DATA_WIDTH +: DATA_WIDTH];
            last_q      <= req_last[pick];
            m_spi_start <= 1'b1;
            busy        <= 1'b1;
            state       <= S_START;
          end
        end
        S_START: begin
          to_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (done_evt) begin
            rsp_data <= m_data_recv;
            ack      <= gnt;
            state    <= S_RESP;
          end else if (to_cnt == TO_END) begin
            // The counter would reach TIMEOUT_CYCLES-1 on this edge: abort and end any burst.
            timeout_err <= 1'b1;
            last_q      <= 1'b1;
            gap_cnt     <= GAP_LOAD;
            state       <= S_GAP;
          end else begin
            to_cnt <= to_cnt + CW'(1);
          end
        end
        S_RESP: begin
          // The RESP cycle is the first of the GAP_CYCLES idle cycles.
          gap_cnt <= GAP_LOAD;
          state   <= S_GAP;
        end
        S_GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GW'(1);
          end else if (!last_q && req[win]) begin
            m_data_send <= req_data[win*DATA_WIDTH +: DATA_WIDTH];
            last_q      <= req_last[win];
            m_spi_start <= 1'b1;
            state       <= S_START;
          end else begin
            gnt   <= '0;
            ptr   <= (win == LAST_IDX) ? '0 : win + IW'(1);
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
